// File: rtl/battle_pkg.sv
// Shared types and defaults for the battleship turn sequencer.
package battle_pkg;

    localparam int GRID_DEF       = 5;
    localparam int NUM_BARCOS_DEF = 5;

    typedef logic [2:0] coord_t;

    typedef enum logic [3:0] {
        IDLE,
        P_TURN,
        P_SHOOT,
        P_SINK,
        P_CHECK,
        PC_TURN,
        PC_SHOOT,
        PC_SINK,
        PC_CHECK,
        GAME_OVER
    } state_t;

    // True when the low n bits of mask are all set (n up to 32).
    function automatic logic mask_all_ones(input logic [31:0] mask, input int n);
        logic [31:0] full;
        full = (32'h1 << n) - 32'h1;
        if (n >= 32) full = '1;
        return (mask & full) == full;
    endfunction

endpackage

// File: rtl/battle_turn_ctrl_turn_timer.sv
// Player-turn countdown: counts while enabled, flags the last allowed cycle.
module turn_timer #(
    parameter int TIMEOUT_CYC = 750000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_term
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == TERM) ? '0 : r_count + W'(1);
        end
    end

    assign o_term = i_en && (r_count == TERM);

endmodule

// File: rtl/battle_turn_ctrl.sv
// Battleship turn sequencer: alternates player/PC shots and detects game over.
// Optional macro HIT_REPEAT_EN: a hit gives the same side another shot.
module battle_turn_ctrl
    import battle_pkg::*;
#(
    parameter int NUM_BARCOS  = NUM_BARCOS_DEF,
    parameter int GRID        = GRID_DEF,
    parameter int TIMEOUT_CYC = 750000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_player_fire,
    input  coord_t                i_player_row,
    input  coord_t                i_player_col,
    input  coord_t                i_pc_row,
    input  coord_t                i_pc_col,
    input  logic                  i_cell_shot,
`ifdef HIT_REPEAT_EN
    input  logic                  i_cell_hit,
`endif
    input  logic [NUM_BARCOS-1:0] i_sunk_pc,
    input  logic [NUM_BARCOS-1:0] i_sunk_player,
    output coord_t                o_shot_row,
    output coord_t                o_shot_col,
    output logic                  o_shot_target,
    output logic                  o_shot_valid,
    output logic                  o_sunk_en,
    output logic                  o_turn,
    output logic                  o_timeout,
    output logic                  o_game_over,
    output logic                  o_winner
);

    localparam logic [3:0] GRID_L = 4'(GRID);

    state_t r_state, w_next;
    coord_t r_shot_row, r_shot_col;
    logic   r_shot_target, r_turn, r_winner;
    logic   w_p_accept, w_pc_accept, w_term, w_auto;
    logic   w_pc_won, w_player_won, w_repeat;

    assign w_p_accept  = (r_state == P_TURN) && i_player_fire && !i_cell_shot &&
                         ({1'b0, i_player_row} < GRID_L) && ({1'b0, i_player_col} < GRID_L);
    assign w_pc_accept = (r_state == PC_TURN) && !i_cell_shot &&
                         ({1'b0, i_pc_row} < GRID_L) && ({1'b0, i_pc_col} < GRID_L);
    assign w_auto       = w_term && !w_p_accept;
    assign w_pc_won     = mask_all_ones(32'(i_sunk_pc), NUM_BARCOS);
    assign w_player_won = mask_all_ones(32'(i_sunk_player), NUM_BARCOS);

`ifdef HIT_REPEAT_EN
    logic r_hit;
    assign w_repeat = r_hit;
`else
    assign w_repeat = 1'b0;
`endif

    turn_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (r_state != P_TURN),
        .i_en    (r_state == P_TURN),
        .o_term  (w_term)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (i_start) w_next = P_TURN;
            P_TURN:    if (w_p_accept || w_auto) w_next = P_SHOOT;
            P_SHOOT:   w_next = P_SINK;
            P_SINK:    w_next = P_CHECK;
            P_CHECK:   w_next = w_pc_won ? GAME_OVER : (w_repeat ? P_TURN : PC_TURN);
            PC_TURN:   if (w_pc_accept) w_next = PC_SHOOT;
            PC_SHOOT:  w_next = PC_SINK;
            PC_SINK:   w_next = PC_CHECK;
            PC_CHECK:  w_next = w_player_won ? GAME_OVER : (w_repeat ? PC_TURN : P_TURN);
            GAME_OVER: w_next = GAME_OVER;
            default:   w_next = IDLE;
        endcase
    end

    // While a side is choosing, the bus shows the live candidate so the board can answer cell_shot.
    always_comb begin
        o_shot_row    = r_shot_row;
        o_shot_col    = r_shot_col;
        o_shot_target = r_shot_target;
        o_shot_valid  = (r_state == P_SHOOT) || (r_state == PC_SHOOT);
        o_sunk_en     = (r_state == P_SINK)  || (r_state == PC_SINK);
        o_timeout     = w_auto;
        o_game_over   = (r_state == GAME_OVER);
        o_turn        = r_turn;
        o_winner      = r_winner;
        if (r_state == P_TURN) begin
            o_shot_row    = i_player_row;
            o_shot_col    = i_player_col;
            o_shot_target = 1'b0;
        end else if (r_state == PC_TURN) begin
            o_shot_row    = i_pc_row;
            o_shot_col    = i_pc_col;
            o_shot_target = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_shot_row    <= '0;
            r_shot_col    <= '0;
            r_shot_target <= 1'b0;
            r_turn        <= 1'b0;
            r_winner      <= 1'b0;
`ifdef HIT_REPEAT_EN
            r_hit         <= 1'b0;
`endif
        end else begin
            if (w_p_accept) begin
                r_shot_row    <= i_player_row;
                r_shot_col    <= i_player_col;
                r_shot_target <= 1'b0;
`ifdef HIT_REPEAT_EN
                r_hit         <= i_cell_hit;
`endif
            end else if (w_auto) begin
                r_shot_row    <= i_pc_row;
                r_shot_col    <= i_pc_col;
                r_shot_target <= 1'b0;
`ifdef HIT_REPEAT_EN
                // cell_hit describes the player's coordinate, not the auto-shot's
                r_hit         <= 1'b0;
`endif
            end else if (w_pc_accept) begin
                r_shot_row    <= i_pc_row;
                r_shot_col    <= i_pc_col;
                r_shot_target <= 1'b1;
`ifdef HIT_REPEAT_EN
                r_hit         <= i_cell_hit;
`endif
            end
            if (r_state == P_CHECK) begin
                if (w_pc_won)       r_winner <= 1'b0;
                else if (!w_repeat) r_turn   <= 1'b1;
            end
            if (r_state == PC_CHECK) begin
                if (w_player_won)   r_winner <= 1'b1;
                else if (!w_repeat) r_turn   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Self-checking bench for battle_turn_ctrl: vector table, corner sequences, random games.
// Define HIT_REPEAT_EN to also exercise the hit-repeat path.
module tb_battle_turn_ctrl;

    localparam int TCYC = 8;
    localparam int GRID = 5;

    typedef struct packed {
        logic       start;
        logic       fire;
        logic [2:0] prow;
        logic [2:0] pcol;
        logic [2:0] pcrow;
        logic [2:0] pccol;
        logic       cshot;
        logic [4:0] spc;
        logic [4:0] spl;
    } in_t;

    // {valid, sunk_en, turn, timeout, game_over, winner, row, col, target}
    typedef logic [12:0] out_t;

    typedef struct {
        in_t  stim;
        out_t want;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start, fire, cshot, cellHit;
    logic [2:0] prow, pcol, pcrow, pccol;
    logic [4:0] spc, spl;
    logic [2:0] shotRow, shotCol;
    logic       shotTarget, shotValid, sunkEn, turn, tout, gameOver, winner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    battle_turn_ctrl #(.NUM_BARCOS(5), .GRID(GRID), .TIMEOUT_CYC(TCYC)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_player_fire (fire),
        .i_player_row  (prow),
        .i_player_col  (pcol),
        .i_pc_row      (pcrow),
        .i_pc_col      (pccol),
        .i_cell_shot   (cshot),
`ifdef HIT_REPEAT_EN
        .i_cell_hit    (cellHit),
`endif
        .i_sunk_pc     (spc),
        .i_sunk_player (spl),
        .o_shot_row    (shotRow),
        .o_shot_col    (shotCol),
        .o_shot_target (shotTarget),
        .o_shot_valid  (shotValid),
        .o_sunk_en     (sunkEn),
        .o_turn        (turn),
        .o_timeout     (tout),
        .o_game_over   (gameOver),
        .o_winner      (winner)
    );

    function automatic in_t mk(input logic st, input logic fi, input logic [2:0] pr, input logic [2:0] pc,
                               input logic [2:0] qr, input logic [2:0] qc, input logic cs,
                               input logic [4:0] sp, input logic [4:0] sl);
        return {st, fi, pr, pc, qr, qc, cs, sp, sl};
    endfunction

    function automatic out_t ex(input logic v, input logic s, input logic t, input logic to,
                                input logic ov, input logic w, input logic [2:0] r,
                                input logic [2:0] c, input logic tg);
        return {v, s, t, to, ov, w, r, c, tg};
    endfunction

    // winner only matters while game_over is high
    function automatic out_t dutOut();
        return {shotValid, sunkEn, turn, tout, gameOver, winner & gameOver, shotRow, shotCol, shotTarget};
    endfunction

    task automatic applyStimulus(input in_t x);
        start = x.start;
        fire  = x.fire;
        prow  = x.prow;
        pcol  = x.pcol;
        pcrow = x.pcrow;
        pccol = x.pccol;
        cshot = x.cshot;
        spc   = x.spc;
        spl   = x.spl;
    endtask

    task automatic checkOutput(input string tag, input out_t act, input out_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h (v,s,turn,to,over,win,row,col,tgt)", tag, act, exp);
        end
    endtask

    // Called at posedge+1: drive, settle, compare, advance to next posedge+1.
    task automatic runCycle(input string tag, input in_t x, input out_t e);
        applyStimulus(x);
        #1;
        checkOutput(tag, dutOut(), e);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        cellHit = 1'b0;
        applyStimulus('0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", dutOut(), '0);
        rst = 1'b1;
    endtask

    // Cycle-level game model: a side waits, then SHOOT/SINK/CHECK follow at fixed latency 1/2/3.
    task automatic randomGame(input int ncyc);
        in_t        x;
        out_t       e;
        bit         acc, to, won;
        bit         started, over, win, side;
        int         lat, timer, overCnt;
        logic [2:0] lr, lc;
        bit         lt;
        started = 0; over = 0; win = 0; side = 0;
        lat = 0; timer = 0; overCnt = 0; lr = 0; lc = 0; lt = 0;
        for (int c = 0; c < ncyc && overCnt < 4; c++) begin
            x.start = ($urandom_range(0, 3) == 0);
            x.fire  = ($urandom_range(0, 2) == 0);
            x.prow  = 3'($urandom_range(0, 6));
            x.pcol  = 3'($urandom_range(0, 6));
            x.pcrow = 3'($urandom_range(0, 6));
            x.pccol = 3'($urandom_range(0, 6));
            x.cshot = ($urandom_range(0, 3) == 0);
            x.spc   = ($urandom_range(0, 19) == 0) ? 5'h1f : 5'($urandom_range(0, 30));
            x.spl   = ($urandom_range(0, 19) == 0) ? 5'h1f : 5'($urandom_range(0, 30));
            e = ex(0, 0, side, 0, over, over & win, lr, lc, lt);
            if (!started) begin
                if (x.start) started = 1;
            end else if (over) begin
                overCnt++;
            end else if (lat == 0) begin
                if (!side) begin
                    acc = x.fire && !x.cshot && (int'(x.prow) < GRID) && (int'(x.pcol) < GRID);
                    to  = (timer == TCYC - 1) && !acc;
                    e   = ex(0, 0, 0, to, 0, 0, x.prow, x.pcol, 0);
                    if (acc) begin
                        lr = x.prow; lc = x.pcol; lt = 0; lat = 1; timer = 0;
                    end else if (to) begin
                        lr = x.pcrow; lc = x.pccol; lt = 0; lat = 1; timer = 0;
                    end else begin
                        timer++;
                    end
                end else begin
                    acc = !x.cshot && (int'(x.pcrow) < GRID) && (int'(x.pccol) < GRID);
                    e   = ex(0, 0, 1, 0, 0, 0, x.pcrow, x.pccol, 1);
                    if (acc) begin
                        lr = x.pcrow; lc = x.pccol; lt = 1; lat = 1;
                    end
                end
            end else begin
                e = ex(lat == 1, lat == 2, side, 0, 0, 0, lr, lc, lt);
                if (lat == 3) begin
                    won = side ? (x.spl == 5'h1f) : (x.spc == 5'h1f);
                    if (won) begin
                        over = 1; win = side;
                    end else begin
                        side = ~side;
                    end
                    lat = 0;
                end else begin
                    lat++;
                end
            end
            runCycle($sformatf("rand c%0d", c), x, e);
        end
    endtask

    vec_t vecs[17];

    initial begin
        // Full player turn then full PC turn, including ignored and resampled shots.
        vecs[0]  = '{mk(1,0,0,0,0,0,0,0,0),     ex(0,0,0,0,0,0,0,0,0)};
        vecs[1]  = '{mk(0,1,5,1,0,0,0,0,0),     ex(0,0,0,0,0,0,5,1,0)};
        vecs[2]  = '{mk(0,1,2,2,0,0,1,0,0),     ex(0,0,0,0,0,0,2,2,0)};
        vecs[3]  = '{mk(0,1,2,3,0,0,0,0,0),     ex(0,0,0,0,0,0,2,3,0)};
        vecs[4]  = '{mk(0,0,7,7,0,0,0,0,0),     ex(1,0,0,0,0,0,2,3,0)};
        vecs[5]  = '{mk(0,0,7,7,0,0,0,0,0),     ex(0,1,0,0,0,0,2,3,0)};
        vecs[6]  = '{mk(0,0,0,0,0,0,0,5'h0f,0), ex(0,0,0,0,0,0,2,3,0)};
        vecs[7]  = '{mk(0,0,0,0,4,1,1,0,0),     ex(0,0,1,0,0,0,4,1,1)};
        vecs[8]  = '{mk(0,0,0,0,5,0,0,0,0),     ex(0,0,1,0,0,0,5,0,1)};
        vecs[9]  = '{mk(0,0,0,0,4,1,1,0,0),     ex(0,0,1,0,0,0,4,1,1)};
        vecs[10] = '{mk(0,0,0,0,4,1,0,0,0),     ex(0,0,1,0,0,0,4,1,1)};
        vecs[11] = '{mk(0,1,1,1,6,6,0,0,0),     ex(1,0,1,0,0,0,4,1,1)};
        vecs[12] = '{mk(0,0,0,0,6,6,0,0,0),     ex(0,1,1,0,0,0,4,1,1)};
        vecs[13] = '{mk(0,0,0,0,0,0,0,0,5'h17), ex(0,0,1,0,0,0,4,1,1)};
        vecs[14] = '{mk(0,0,0,0,0,0,0,0,0),     ex(0,0,0,0,0,0,0,0,0)};
        vecs[15] = '{mk(0,0,3,2,0,0,0,0,0),     ex(0,0,0,0,0,0,3,2,0)};
        vecs[16] = '{mk(1,0,1,0,0,0,0,0,0),     ex(0,0,0,0,0,0,1,0,0)};

        cellHit = 1'b0;
        applyStimulus('0);
        #1 rst = 1'b0;
        doReset();
        for (int i = 0; i < 17; i++) runCycle($sformatf("vec%0d", i), vecs[i].stim, vecs[i].want);

        // Timeout after TCYC idle player cycles; invalid fires do not stop the timer.
        doReset();
        runCycle("to idle", mk(1,0,0,0,1,4,0,0,0), '0);
        for (int k = 0; k < TCYC; k++) begin
            if (k == 2)      runCycle($sformatf("to k%0d", k), mk(0,1,5,0,1,4,0,0,0), ex(0,0,0,0,0,0,5,0,0));
            else if (k == 4) runCycle($sformatf("to k%0d", k), mk(0,1,3,3,1,4,1,0,0), ex(0,0,0,0,0,0,3,3,0));
            else runCycle($sformatf("to k%0d", k), mk(0,0,2,0,1,4,0,0,0), ex(0,0,0,k == TCYC-1,0,0,2,0,0));
        end
        runCycle("to shoot", mk(0,0,2,0,6,6,0,0,0), ex(1,0,0,0,0,0,1,4,0));
        runCycle("to sink",  mk(0,0,2,0,6,6,0,0,0), ex(0,1,0,0,0,0,1,4,0));
        runCycle("to check", mk(0,0,2,0,6,6,0,0,0), ex(0,0,0,0,0,0,1,4,0));
        runCycle("to pcturn", mk(0,0,2,0,1,4,1,0,0), ex(0,0,1,0,0,0,1,4,1));

        // Fire in the same cycle as the timeout wins and suppresses the pulse.
        doReset();
        runCycle("tie idle", mk(1,0,0,0,0,0,0,0,0), '0);
        for (int k = 0; k < TCYC - 1; k++) runCycle("tie wait", mk(0,0,1,2,2,2,0,0,0), ex(0,0,0,0,0,0,1,2,0));
        runCycle("tie fire",  mk(0,1,0,4,2,2,0,0,0), ex(0,0,0,0,0,0,0,4,0));
        runCycle("tie shoot", mk(0,0,3,3,2,2,0,0,0), ex(1,0,0,0,0,0,0,4,0));

        // Player sinks the whole fleet; game over is sticky.
        doReset();
        runCycle("go idle",  mk(1,0,0,0,0,0,0,0,0), '0);
        runCycle("go fire",  mk(0,1,1,1,0,0,0,0,0), ex(0,0,0,0,0,0,1,1,0));
        runCycle("go shoot", mk(0,0,0,0,0,0,0,0,0), ex(1,0,0,0,0,0,1,1,0));
        runCycle("go sink",  mk(0,0,0,0,0,0,0,0,0), ex(0,1,0,0,0,0,1,1,0));
        runCycle("go check", mk(0,0,0,0,0,0,0,5'h1f,0), ex(0,0,0,0,0,0,1,1,0));
        for (int k = 0; k < 4; k++)
            runCycle($sformatf("go sticky%0d", k), mk(1,1,2,2,3,3,0,5'h1f,5'h1f), ex(0,0,0,0,1,0,1,1,0));

        // Asynchronous reset in the middle of the sink cycle.
        doReset();
        runCycle("ar idle",  mk(1,0,0,0,0,0,0,0,0), '0);
        runCycle("ar fire",  mk(0,1,4,4,0,0,0,0,0), ex(0,0,0,0,0,0,4,4,0));
        runCycle("ar shoot", mk(0,0,0,0,0,0,0,0,0), ex(1,0,0,0,0,0,4,4,0));
        applyStimulus('0);
        #1;
        checkOutput("ar sink", dutOut(), ex(0,1,0,0,0,0,4,4,0));
        #1 rst = 1'b0;
        #1;
        checkOutput("ar async", dutOut(), '0);
        @(posedge clk);
        #1 rst = 1'b1;
        runCycle("ar idle1", mk(0,1,3,3,0,0,0,0,0), '0);
        runCycle("ar idle2", mk(1,1,3,3,0,0,0,0,0), '0);
        runCycle("ar pturn", mk(0,0,3,3,0,0,0,0,0), ex(0,0,0,0,0,0,3,3,0));

`ifdef HIT_REPEAT_EN
        // A player hit keeps the turn with the player.
        doReset();
        runCycle("hr idle", mk(1,0,0,0,0,0,0,0,0), '0);
        cellHit = 1'b1;
        runCycle("hr fire", mk(0,1,0,0,0,0,0,0,0), ex(0,0,0,0,0,0,0,0,0));
        cellHit = 1'b0;
        runCycle("hr shoot", mk(0,0,2,1,0,0,0,0,0), ex(1,0,0,0,0,0,0,0,0));
        runCycle("hr sink",  mk(0,0,2,1,0,0,0,0,0), ex(0,1,0,0,0,0,0,0,0));
        runCycle("hr check", mk(0,0,2,1,0,0,0,0,0), ex(0,0,0,0,0,0,0,0,0));
        runCycle("hr again", mk(0,0,2,1,3,3,0,0,0), ex(0,0,0,0,0,0,2,1,0));
`endif

        for (int g = 0; g < 6; g++) begin
            doReset();
            randomGame(400);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
